// File: rtl/regs_sb.sv
// Multi-read-port register file with same-cycle write forwarding and a
// per-register write-pending scoreboard for RAW/WAW hazard detection.
module regs_sb #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_RD         = 2,
    parameter int ZERO_R0        = 0,
    parameter int INIT_R1        = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]          i_wr_addr,
    input  logic [DATA_WIDTH-1:0]              i_wr_data,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]       o_rd_data,
    output logic [NUM_RD-1:0]                  o_rd_busy,
    input  logic                               i_iss_en,
    input  logic [REG_ADDR_WIDTH-1:0]          i_iss_addr,
    output logic                               o_iss_waw,
    output logic [REG_ADDR_WIDTH:0]            o_pend_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int CW       = REG_ADDR_WIDTH + 1;

    function automatic logic [CW-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [DATA_WIDTH-1:0]  r_mem [NUM_REGS];
    logic [NUM_REGS-1:0]    r_busy;
    logic [CW-1:0]          r_pend_cnt;

    logic                   w_r0_zero;
    logic                   w_wr_ok;
    logic                   w_iss_ok;
    logic [NUM_REGS-1:0]    w_clr_mask;
    logic [NUM_REGS-1:0]    w_set_mask;
    logic [NUM_REGS-1:0]    w_busy_nxt;

    assign w_r0_zero = (ZERO_R0 != 0);

    // Qualify write/issue against the hardwired r0; set beats clear on the same register.
    always_comb begin
        w_wr_ok    = i_wr_en  && !(w_r0_zero && (i_wr_addr  == {REG_ADDR_WIDTH{1'b0}}));
        w_iss_ok   = i_iss_en && !(w_r0_zero && (i_iss_addr == {REG_ADDR_WIDTH{1'b0}}));
        w_clr_mask = {NUM_REGS{1'b0}};
        w_set_mask = {NUM_REGS{1'b0}};
        if (i_wr_en) begin
            w_clr_mask = NUM_REGS'(1'b1) << i_wr_addr;
        end else begin
            w_clr_mask = {NUM_REGS{1'b0}};
        end
        if (w_iss_ok) begin
            w_set_mask = NUM_REGS'(1'b1) << i_iss_addr;
        end else begin
            w_set_mask = {NUM_REGS{1'b0}};
        end
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Register array, scoreboard and pending count update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= (i == 1) ? DATA_WIDTH'(INIT_R1) : {DATA_WIDTH{1'b0}};
            end
            r_busy     <= {NUM_REGS{1'b0}};
            r_pend_cnt <= {CW{1'b0}};
        end else begin
            if (w_wr_ok) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end else begin
                r_mem[i_wr_addr] <= r_mem[i_wr_addr];
            end
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= popcount(w_busy_nxt);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [REG_ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0]     w_data;
        logic                      w_busy;
        logic                      w_hit;

        assign w_addr = i_rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign w_hit  = i_wr_en && (i_wr_addr == w_addr);

        // Read mux: reset gating, hardwired r0, then writeback bypass, then the array.
        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr] & ~w_hit;
            if (i_rst) begin
                w_data = {DATA_WIDTH{1'b0}};
                w_busy = 1'b0;
            end else if (w_r0_zero && (w_addr == {REG_ADDR_WIDTH{1'b0}})) begin
                w_data = {DATA_WIDTH{1'b0}};
            end else if (w_hit && w_wr_ok) begin
                w_data = i_wr_data;
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign o_rd_busy[k]                          = w_busy;
    end

    // WAW flag looks only at the pre-edge busy bit, ignoring a same-cycle writeback.
    assign o_iss_waw  = ~i_rst & i_iss_en & r_busy[i_iss_addr];
    assign o_pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regs_sb.sv
// Directed and random checks of regs_sb (default and ZERO_R0=1 instances)
// against an array-based reference model of the register file and scoreboard.
module tb_regs_sb;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int NREG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, wr_en, iss_en;
    logic [AW-1:0]      wr_addr, iss_addr;
    logic [DW-1:0]      wr_data;
    logic [NR*AW-1:0]   rd_addr;

    logic [NR*DW-1:0]   rd_data_n, rd_data_z;
    logic [NR-1:0]      rd_busy_n, rd_busy_z;
    logic               waw_n, waw_z;
    logic [AW:0]        pend_n, pend_z;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_mem  [2][NREG];
    bit            m_busy [2][NREG];
    int            m_pend [2];
    bit            m_valid = 1'b0;

    regs_sb #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_R0(0), .INIT_R1(1)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_iss_waw(waw_n), .o_pend_cnt(pend_n));

    regs_sb #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_R0(1), .INIT_R1(1)) dut_z (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_z), .o_rd_busy(rd_busy_z),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_iss_waw(waw_z), .o_pend_cnt(pend_z));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
        if (rst) return 16'h0000;
        if (z == 1 && a == 4'd0) return 16'h0000;
        if (wr_en && wr_addr == a && !(z == 1 && wr_addr == 4'd0)) return wr_data;
        return m_mem[z][a];
    endfunction

    function automatic logic exp_busy(input int z, input logic [AW-1:0] a);
        if (rst) return 1'b0;
        return m_busy[z][a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic check_variant(input int z, input logic [NR*DW-1:0] rdd, input logic [NR-1:0] rdb,
                                 input logic waw, input logic [AW:0] pc);
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            chk(z ? "model_rd_data_z" : "model_rd_data_n", 32'(rdd[k*DW +: DW]), 32'(exp_rd(z, a)));
            chk(z ? "model_rd_busy_z" : "model_rd_busy_n", 32'(rdb[k]), 32'(exp_busy(z, a)));
        end
        chk(z ? "model_waw_z" : "model_waw_n", 32'(waw), 32'(!rst && iss_en && m_busy[z][iss_addr]));
        if (m_valid) chk(z ? "model_pend_z" : "model_pend_n", 32'(pc), 32'(m_pend[z]));
    endtask

    task automatic model_update(input int z);
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[z][i]  = 16'h0000;
                m_busy[z][i] = 1'b0;
            end
            m_mem[z][1] = 16'h0001;
        end else begin
            if (wr_en && !(z == 1 && wr_addr == 4'd0)) m_mem[z][wr_addr] = wr_data;
            if (wr_en) m_busy[z][wr_addr] = 1'b0;
            if (iss_en && !(z == 1 && iss_addr == 4'd0)) m_busy[z][iss_addr] = 1'b1;
        end
        m_pend[z] = 0;
        for (int i = 0; i < NREG; i++) m_pend[z] += int'(m_busy[z][i]);
    endtask

    task automatic apply(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit ie, input logic [AW-1:0] ia);
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = {a1, a0}; iss_en = ie; iss_addr = ia;
        #1;
        check_variant(0, rd_data_n, rd_busy_n, waw_n, pend_n);
        check_variant(1, rd_data_z, rd_busy_z, waw_z, pend_z);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(0);
        model_update(1);
        if (rst) m_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; iss_en = 1'b0;
        wr_addr = 4'd0; iss_addr = 4'd0; wr_data = 16'h0000; rd_addr = 8'h00;

        // Reset, then read r0, r1, r5
        apply(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 1'b0, 4'd0);
        chk("reset_r0", 32'(rd_data_n[15:0]), 32'h0000);
        chk("reset_r1", 32'(rd_data_n[31:16]), 32'h0001);
        chk("reset_busy", 32'(rd_busy_n), 32'h0);
        chk("reset_pend", 32'(pend_n), 32'h0);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0, 4'd0);
        chk("reset_r5", 32'(rd_data_n[15:0]), 32'h0000);
        tick();

        // Forwarding then stored value
        apply(1'b0, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd0, 1'b0, 4'd0);
        chk("fwd_same_cycle", 32'(rd_data_n[15:0]), 32'hBEEF);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3, 1'b0, 4'd0);
        chk("fwd_stored", 32'(rd_data_n[31:16]), 32'hBEEF);
        tick();

        // Issue r4, then writeback r4
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd4); tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd4, 4'd0, 1'b0, 4'd0);
        chk("iss_busy", 32'(rd_busy_n[0]), 32'h1);
        chk("iss_pend", 32'(pend_n), 32'h1);
        tick();
        apply(1'b0, 1'b1, 4'd4, 16'h4444, 4'd4, 4'd0, 1'b0, 4'd0);
        chk("wb_busy_resolved", 32'(rd_busy_n[0]), 32'h0);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd4, 4'd0, 1'b0, 4'd0);
        chk("wb_pend", 32'(pend_n), 32'h0);
        tick();

        // Same-cycle issue and writeback to busy r6
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd6); tick();
        apply(1'b0, 1'b1, 4'd6, 16'h0066, 4'd6, 4'd0, 1'b1, 4'd6);
        chk("same_waw", 32'(waw_n), 32'h1);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd6, 4'd0, 1'b0, 4'd0);
        chk("same_busy", 32'(rd_busy_n[0]), 32'h1);
        chk("same_pend", 32'(pend_n), 32'h1);
        tick();
        apply(1'b0, 1'b1, 4'd6, 16'h0606, 4'd0, 4'd0, 1'b0, 4'd0); tick();

        // Hardwired r0
        apply(1'b0, 1'b1, 4'd0, 16'h1234, 4'd0, 4'd0, 1'b1, 4'd0);
        chk("z_r0_fwd", 32'(rd_data_z[15:0]), 32'h0000);
        chk("n_r0_fwd", 32'(rd_data_n[15:0]), 32'h1234);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
        chk("z_r0_data", 32'(rd_data_z[15:0]), 32'h0000);
        chk("z_r0_busy", 32'(rd_busy_z[0]), 32'h0);
        chk("z_r0_pend", 32'(pend_z), 32'h0);
        tick();

        // Mid-operation reset
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd2); tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd7); tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd7, 1'b0, 4'd0);
        chk("mid_pend", 32'(pend_z), 32'h2);
        tick();
        apply(1'b1, 1'b1, 4'd2, 16'hAAAA, 4'd2, 4'd7, 1'b0, 4'd0);
        chk("mid_rst_forced", 32'(rd_data_z), 32'h0);
        tick();
        apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd7, 1'b0, 4'd0);
        chk("mid_r2", 32'(rd_data_z[15:0]), 32'h0000);
        chk("mid_busy", 32'(rd_busy_z), 32'h0);
        chk("mid_pend_clr", 32'(pend_z), 32'h0);
        tick();

        // Random traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  16'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
